// File: rtl/wb_master_arbiter_pkg.sv
// Shared types and the round-robin search used by wb_master_arbiter.
// Holds the arbiter state encoding and the next-owner search function.
package wb_master_arbiter_pkg;

  localparam int unsigned MAX_MASTERS = 8;
  localparam int unsigned OWNER_W     = 3;
  localparam int unsigned CNT_W       = OWNER_W + 1;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Returns {found, index} of the first requester after 'last', wrapping modulo 'count'.
  // The offsets are scanned from farthest to nearest, so the nearest hit is the one kept.
  function automatic logic [CNT_W-1:0] rr_next(
    input logic [MAX_MASTERS-1:0] req,
    input logic [OWNER_W-1:0]     last,
    input logic [CNT_W-1:0]       count
  );
    logic [CNT_W-1:0] res;
    logic [CNT_W-1:0] off;
    logic [CNT_W-1:0] cand;
    res = '0;
    for (int unsigned k = 0; k < MAX_MASTERS; k++) begin
      off  = CNT_W'(MAX_MASTERS - k);
      cand = CNT_W'(last) + off;
      if (cand >= count) begin
        cand = cand - count;
      end
      if ((off <= count) && req[cand[OWNER_W-1:0]]) begin
        res = {1'b1, cand[OWNER_W-1:0]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_master_arbiter_rr_pick.sv
// Combinational round-robin pick: request vector plus last owner gives a one-hot winner.
module wb_master_arbiter_rr_pick
  import wb_master_arbiter_pkg::*;
#(
  parameter int unsigned MASTER_COUNT = 2
) (
  input  logic [MASTER_COUNT-1:0] req,
  input  logic [OWNER_W-1:0]      last_owner,
  output logic [MASTER_COUNT-1:0] pick_c
);

  logic [MAX_MASTERS-1:0] req_ext;
  logic [CNT_W-1:0]       hit;

  always_comb begin
    req_ext = MAX_MASTERS'(req);
    hit     = rr_next(req_ext, last_owner, CNT_W'(MASTER_COUNT));
    pick_c  = '0;
    if (hit[CNT_W-1]) begin
      pick_c = MASTER_COUNT'(1) << hit[OWNER_W-1:0];
    end
  end

endmodule

// File: rtl/wb_master_arbiter.sv
// Round-robin arbiter sharing one Wishbone pipelined port between MASTER_COUNT masters.
// Define WB_ARB_TIMEOUT_EN to add the hung-transfer watchdog and the timeout_flag port.
module wb_master_arbiter
  import wb_master_arbiter_pkg::*;
#(
  parameter int unsigned MASTER_COUNT   = 2,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TAG_WIDTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                                  sys_clk,
  input  logic                                  sys_rst,
  input  logic [MASTER_COUNT-1:0]               m_cyc,
  input  logic [MASTER_COUNT-1:0]               m_stb,
  input  logic [MASTER_COUNT-1:0]               m_we,
  input  logic [MASTER_COUNT*TAG_WIDTH-1:0]     m_tag,
  input  logic [MASTER_COUNT*(DATA_WIDTH/8)-1:0] m_sel,
  input  logic [MASTER_COUNT*ADDR_WIDTH-1:0]    m_adr,
  input  logic [MASTER_COUNT*DATA_WIDTH-1:0]    m_mosi,
  output logic [MASTER_COUNT*DATA_WIDTH-1:0]    m_miso,
  output logic [MASTER_COUNT-1:0]               m_ack,
  output logic [MASTER_COUNT-1:0]               m_err,
  output logic                                  s_cyc,
  output logic                                  s_stb,
  output logic                                  s_we,
  output logic [TAG_WIDTH-1:0]                  s_tag,
  output logic [DATA_WIDTH/8-1:0]               s_sel,
  output logic [ADDR_WIDTH-1:0]                 s_adr,
  output logic [DATA_WIDTH-1:0]                 s_mosi,
  input  logic [DATA_WIDTH-1:0]                 s_miso,
  input  logic                                  s_ack,
  input  logic                                  s_err,
`ifdef WB_ARB_TIMEOUT_EN
  output logic                                  timeout_flag,
`endif
  output logic [MASTER_COUNT-1:0]               grant
);

  localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;

  if (MASTER_COUNT < 1 || MASTER_COUNT > MAX_MASTERS || TIMEOUT_CYCLES < 2 ||
      (DATA_WIDTH % 8) != 0) begin : g_param_check
    $error("wb_master_arbiter: unsupported parameter set");
  end

  arb_state_t               state;
  logic [OWNER_W-1:0]       last_owner;
  logic [OWNER_W-1:0]       owner_idx;
  logic [MASTER_COUNT-1:0]  pick_c;
  logic                     owner_cyc;
  logic                     owner_stb;
  logic                     owner_we;
  logic [TAG_WIDTH-1:0]     owner_tag;
  logic [SEL_WIDTH-1:0]     owner_sel;
  logic [ADDR_WIDTH-1:0]    owner_adr;
  logic [DATA_WIDTH-1:0]    owner_mosi;
  logic                     kill;
  logic                     to_pulse;

  wb_master_arbiter_rr_pick #(
    .MASTER_COUNT (MASTER_COUNT)
  ) u_rr_pick (
    .req        (m_cyc),
    .last_owner (last_owner),
    .pick_c     (pick_c)
  );

  // Grant is held for the whole cycle; every release passes through one idle bubble.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= ARB_IDLE;
      grant      <= '0;
      last_owner <= OWNER_W'(MASTER_COUNT - 1);
    end else begin
      case (state)
        ARB_IDLE: begin
          if (|m_cyc) begin
            grant <= pick_c;
            state <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (!owner_cyc) begin
            grant      <= '0;
            last_owner <= owner_idx;
            state      <= ARB_IDLE;
          end
        end
        default: begin
          grant <= '0;
          state <= ARB_IDLE;
        end
      endcase
    end
  end

  // AND-OR mux of the owner's request; an empty grant yields all zeros.
  always_comb begin
    owner_cyc  = 1'b0;
    owner_stb  = 1'b0;
    owner_we   = 1'b0;
    owner_idx  = '0;
    owner_tag  = '0;
    owner_sel  = '0;
    owner_adr  = '0;
    owner_mosi = '0;
    for (int unsigned i = 0; i < MASTER_COUNT; i++) begin
      if (grant[i]) begin
        owner_cyc  = owner_cyc | m_cyc[i];
        owner_stb  = owner_stb | m_stb[i];
        owner_we   = owner_we  | m_we[i];
        owner_idx  = OWNER_W'(i);
        owner_tag  = owner_tag  | m_tag[i*TAG_WIDTH +: TAG_WIDTH];
        owner_sel  = owner_sel  | m_sel[i*SEL_WIDTH +: SEL_WIDTH];
        owner_adr  = owner_adr  | m_adr[i*ADDR_WIDTH +: ADDR_WIDTH];
        owner_mosi = owner_mosi | m_mosi[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    s_cyc  = owner_cyc & ~kill;
    s_stb  = owner_stb & ~kill;
    s_we   = owner_we;
    s_tag  = owner_tag;
    s_sel  = owner_sel;
    s_adr  = owner_adr;
    s_mosi = owner_mosi;
    m_ack  = grant & {MASTER_COUNT{s_ack}};
    m_err  = grant & {MASTER_COUNT{s_err | to_pulse}};
    m_miso = {MASTER_COUNT{s_miso}};
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TO_W-1:0] to_cnt;
  logic [7:0]      pending;
  logic            to_kill;
  logic            resp_c;
  logic            to_active_c;
  logic            to_fire_c;
  logic            issue_c;
  logic            retire_c;

  assign kill        = to_kill;
  assign resp_c      = s_ack | s_err;
  assign issue_c     = s_stb && (pending != 8'hFF);
  assign retire_c    = resp_c && (pending != 8'h00);
  assign to_active_c = (state == ARB_BUSY) && owner_cyc && !to_kill &&
                       (owner_stb || (pending != 8'h00));
  assign to_fire_c   = to_active_c && !resp_c &&
                       (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts while a beat is pending, errors out once, then holds s_cyc low.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      to_cnt       <= '0;
      pending      <= '0;
      to_kill      <= 1'b0;
      to_pulse     <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      to_pulse <= to_fire_c;
      if (to_fire_c) begin
        timeout_flag <= 1'b1;
      end
      if ((state != ARB_BUSY) || !owner_cyc) begin
        to_cnt  <= '0;
        pending <= '0;
        to_kill <= 1'b0;
      end else begin
        if (to_fire_c) begin
          to_kill <= 1'b1;
        end
        if (resp_c) begin
          to_cnt <= '0;
        end else if (to_active_c) begin
          to_cnt <= to_cnt + TO_W'(1);
        end
        pending <= pending + 8'(issue_c) - 8'(retire_c);
      end
    end
  end
`else
  assign kill     = 1'b0;
  assign to_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Self-checking bench for wb_master_arbiter with three masters and a behavioural round-robin model.
module tb_wb_master_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TW = 4;
  localparam int SW = DW / 8;

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic [N-1:0]      m_cyc, m_stb, m_we;
  logic [N*TW-1:0]   m_tag;
  logic [N*SW-1:0]   m_sel;
  logic [N*AW-1:0]   m_adr;
  logic [N*DW-1:0]   m_mosi;
  logic [N*DW-1:0]   m_miso;
  logic [N-1:0]      m_ack, m_err;
  logic              s_cyc, s_stb, s_we;
  logic [TW-1:0]     s_tag;
  logic [SW-1:0]     s_sel;
  logic [AW-1:0]     s_adr;
  logic [DW-1:0]     s_mosi;
  logic [DW-1:0]     s_miso;
  logic              s_ack, s_err;
  logic [N-1:0]      grant;
`ifdef WB_ARB_TIMEOUT_EN
  logic              timeout_flag;
`endif

  int passed = 0;
  int total  = 0;
  int exp_owner;
  int exp_last;

  always #5 sys_clk = ~sys_clk;

  wb_master_arbiter #(
    .MASTER_COUNT   (N),
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .TAG_WIDTH      (TW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .sys_clk (sys_clk), .sys_rst (sys_rst),
    .m_cyc (m_cyc), .m_stb (m_stb), .m_we (m_we), .m_tag (m_tag),
    .m_sel (m_sel), .m_adr (m_adr), .m_mosi (m_mosi), .m_miso (m_miso),
    .m_ack (m_ack), .m_err (m_err),
    .s_cyc (s_cyc), .s_stb (s_stb), .s_we (s_we), .s_tag (s_tag),
    .s_sel (s_sel), .s_adr (s_adr), .s_mosi (s_mosi), .s_miso (s_miso),
    .s_ack (s_ack), .s_err (s_err),
`ifdef WB_ARB_TIMEOUT_EN
    .timeout_flag (timeout_flag),
`endif
    .grant (grant)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0; m_tag = '0; m_sel = '0;
    m_adr = '0; m_mosi = '0; s_miso = '0; s_ack = 1'b0; s_err = 1'b0;
  endtask

  // Spec-level model: owner -1 means idle; searching starts one past the last owner.
  task automatic model_edge();
    int cand;
    bit found;
    if (exp_owner < 0) begin
      found = 1'b0;
      for (int o = 1; o <= N; o++) begin
        cand = (exp_last + o) % N;
        if (!found && m_cyc[cand]) begin
          exp_owner = cand;
          found = 1'b1;
        end
      end
    end else if (!m_cyc[exp_owner]) begin
      exp_last  = exp_owner;
      exp_owner = -1;
    end
  endtask

  function automatic logic [N-1:0] exp_grant();
    if (exp_owner < 0) return '0;
    return N'(1) << exp_owner;
  endfunction

  task automatic do_reset();
    idle_inputs();
    sys_rst = 1'b1;
    tick();
    tick();
    sys_rst = 1'b0;
    exp_owner = -1;
    exp_last  = N - 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    sys_rst = 1'b1;
    tick();
    total++; if (grant !== '0) $display("FAIL reset_grant: got %b expected 000", grant); else passed++;
    total++; if ({s_cyc, s_stb, s_we} !== 3'b000) $display("FAIL reset_s_ctrl: got %b expected 000", {s_cyc, s_stb, s_we}); else passed++;
    total++; if ({m_ack, m_err} !== '0) $display("FAIL reset_ack_err: got %b expected 000000", {m_ack, m_err}); else passed++;
    total++; if (s_adr !== '0) $display("FAIL reset_s_adr: got %h expected 0", s_adr); else passed++;
    sys_rst = 1'b0;
    exp_owner = -1;
    exp_last  = N - 1;
    tick();
  endtask

  task automatic test_single_master();
    do_reset();
    m_cyc = 3'b001; m_stb = 3'b001; m_adr[AW-1:0] = 32'h0000_4000;
    #1;
    total++; if (s_cyc !== 1'b0) $display("FAIL single_latency: s_cyc got %b expected 0", s_cyc); else passed++;
    tick();
    total++; if (grant !== 3'b001) $display("FAIL single_grant: got %b expected 001", grant); else passed++;
    total++; if (s_cyc !== 1'b1 || s_adr !== 32'h0000_4000) $display("FAIL single_s_cyc_adr: got %b/%h expected 1/00004000", s_cyc, s_adr); else passed++;
    s_ack = 1'b1; s_miso = 32'hDEAD_BEEF;
    #1;
    total++; if (m_ack !== 3'b001) $display("FAIL single_ack: got %b expected 001", m_ack); else passed++;
    total++; if (m_miso[DW-1:0] !== 32'hDEAD_BEEF) $display("FAIL single_miso0: got %h expected deadbeef", m_miso[DW-1:0]); else passed++;
    total++; if (m_miso[2*DW +: DW] !== 32'hDEAD_BEEF) $display("FAIL single_miso2: got %h expected deadbeef", m_miso[2*DW +: DW]); else passed++;
    tick();
    s_ack = 1'b0; m_stb = '0; m_cyc = '0;
    #1;
    total++; if (s_cyc !== 1'b0) $display("FAIL single_release: s_cyc got %b expected 0", s_cyc); else passed++;
    tick();
    total++; if (grant !== '0) $display("FAIL single_idle: got %b expected 000", grant); else passed++;
    idle_inputs();
  endtask

  task automatic test_contention();
    do_reset();
    m_cyc = 3'b011;
    tick();
    total++; if (grant !== 3'b001) $display("FAIL contention_first: got %b expected 001", grant); else passed++;
    tick();
    m_cyc = 3'b010;
    #1;
    total++; if (s_cyc !== 1'b0) $display("FAIL contention_drop: s_cyc got %b expected 0", s_cyc); else passed++;
    tick();
    total++; if (grant !== '0) $display("FAIL contention_bubble: got %b expected 000", grant); else passed++;
    tick();
    total++; if (grant !== 3'b010 || s_cyc !== 1'b1) $display("FAIL contention_second: got %b/%b expected 010/1", grant, s_cyc); else passed++;
    m_cyc = '0;
    tick();
  endtask

  task automatic test_fairness();
    logic [N-1:0] prev;
    logic [N-1:0] want;
    int k;
    do_reset();
    m_cyc = '1;
    prev = '0;
    for (int g = 0; g < 6; g++) begin
      for (int w = 0; w < 10 && grant == '0; w++) tick();
      want = N'(1) << (g % N);
      total++; if (grant !== want || grant === prev) $display("FAIL fairness_grant%0d: got %b expected %b", g, grant, want); else passed++;
      prev = grant;
      k = g % N;
      m_cyc[k] = 1'b0;
      tick();
      total++; if (grant !== '0) $display("FAIL fairness_bubble%0d: got %b expected 000", g, grant); else passed++;
      m_cyc[k] = 1'b1;
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_hold();
    int acks0;
    bit leak;
    do_reset();
    m_cyc = 3'b011;
    tick();
    total++; if (grant !== 3'b001) $display("FAIL hold_grant: got %b expected 001", grant); else passed++;
    acks0 = 0;
    leak  = 1'b0;
    for (int c = 0; c < 6; c++) begin
      m_stb[0] = (c < 4);
      m_adr[AW-1:0] = 32'h1000 + 32'(4 * c);
      s_ack = (c >= 1 && c <= 4);
      #1;
      if (m_ack[0]) acks0++;
      if (m_ack[1] !== 1'b0) leak = 1'b1;
      tick();
    end
    total++; if (acks0 !== 4) $display("FAIL hold_acks: got %0d expected 4", acks0); else passed++;
    total++; if (leak !== 1'b0) $display("FAIL hold_leak: m_ack[1] seen %b expected 0", leak); else passed++;
    total++; if (grant !== 3'b001) $display("FAIL hold_keep: got %b expected 001", grant); else passed++;
    s_ack = 1'b0; m_stb = '0; m_cyc[0] = 1'b0;
    tick();
    tick();
    total++; if (grant !== 3'b010) $display("FAIL hold_handover: got %b expected 010", grant); else passed++;
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    m_cyc = 3'b001;
    tick();
    total++; if (grant !== 3'b001) $display("FAIL areset_pre: got %b expected 001", grant); else passed++;
    #2;
    sys_rst = 1'b1;
    #1;
    total++; if (s_cyc !== 1'b0 || grant !== '0) $display("FAIL areset_mid: got %b/%b expected 0/000", s_cyc, grant); else passed++;
    m_cyc = 3'b011;
    #1;
    sys_rst = 1'b0;
    exp_owner = -1;
    exp_last  = N - 1;
    model_edge();
    tick();
    total++; if (grant !== exp_grant() || grant !== 3'b001) $display("FAIL areset_post: got %b expected 001", grant); else passed++;
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0]  nc;
    logic [N-1:0]  ack_exp, err_exp;
    logic [AW-1:0] adr_exp;
    logic [DW-1:0] mosi_exp;
    int k;
    do_reset();
    for (int it = 0; it < 400; it++) begin
      for (int i = 0; i < N; i++) begin
        if (i == exp_owner) nc[i] = ($urandom_range(0, 3) != 0);
        else                nc[i] = 1'($urandom_range(0, 1));
        m_adr[i*AW +: AW]  = $urandom();
        m_mosi[i*DW +: DW] = $urandom();
        m_tag[i*TW +: TW]  = 4'($urandom());
        m_sel[i*SW +: SW]  = 4'($urandom());
      end
      m_cyc  = nc;
      m_stb  = nc & N'($urandom());
      m_we   = N'($urandom());
      s_miso = $urandom();
      s_ack  = ($urandom_range(0, 2) == 0);
      s_err  = ($urandom_range(0, 7) == 0);
      #2;
      if (exp_owner >= 0) begin
        k = exp_owner;
        ack_exp  = N'(s_ack) << k;
        err_exp  = N'(s_err) << k;
        adr_exp  = m_adr[k*AW +: AW];
        mosi_exp = m_mosi[k*DW +: DW];
        total++; if ({s_cyc, s_stb, s_we} !== {m_cyc[k], m_stb[k], m_we[k]}) $display("FAIL rand_ctrl it%0d: got %b expected %b", it, {s_cyc, s_stb, s_we}, {m_cyc[k], m_stb[k], m_we[k]}); else passed++;
        total++; if (s_adr !== adr_exp || s_mosi !== mosi_exp) $display("FAIL rand_data it%0d: got %h/%h expected %h/%h", it, s_adr, s_mosi, adr_exp, mosi_exp); else passed++;
        total++; if (s_tag !== m_tag[k*TW +: TW] || s_sel !== m_sel[k*SW +: SW]) $display("FAIL rand_tagsel it%0d: got %h/%h expected %h/%h", it, s_tag, s_sel, m_tag[k*TW +: TW], m_sel[k*SW +: SW]); else passed++;
      end else begin
        ack_exp = '0;
        err_exp = '0;
        total++; if ({s_cyc, s_stb} !== 2'b00) $display("FAIL rand_idle it%0d: got %b expected 00", it, {s_cyc, s_stb}); else passed++;
      end
      total++; if (m_ack !== ack_exp || m_err !== err_exp) $display("FAIL rand_resp it%0d: got %b/%b expected %b/%b", it, m_ack, m_err, ack_exp, err_exp); else passed++;
      total++; if (m_miso[(it % N)*DW +: DW] !== s_miso) $display("FAIL rand_miso it%0d: got %h expected %h", it, m_miso[(it % N)*DW +: DW], s_miso); else passed++;
      model_edge();
      tick();
      total++; if (grant !== exp_grant()) $display("FAIL rand_grant it%0d: got %b expected %b", it, grant, exp_grant()); else passed++;
    end
    idle_inputs();
    tick();
    tick();
  endtask

`ifdef WB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int first;
    int pulses;
    do_reset();
    m_cyc = 3'b001; m_stb = 3'b001;
    tick();
    first  = -1;
    pulses = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      m_stb = '0;
      if (m_err[0]) begin
        pulses++;
        if (first < 0) first = c;
      end
    end
    total++; if (first !== 16 || pulses !== 1) $display("FAIL timeout_pulse: got cycle %0d count %0d expected cycle 16 count 1", first, pulses); else passed++;
    total++; if (s_cyc !== 1'b0 || timeout_flag !== 1'b1) $display("FAIL timeout_state: got %b/%b expected 0/1", s_cyc, timeout_flag); else passed++;
    idle_inputs();
    tick();
    tick();
  endtask
`endif

  initial begin
    sys_rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_master();
    test_contention();
    test_fairness();
    test_hold();
    test_async_reset();
    test_random();
`ifdef WB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/wb_master_arbiter.md
Name: wb_master_arbiter

Overview:
- Round-robin arbiter that shares one Wishbone B4 pipelined-classic downstream port between MASTER_COUNT upstream masters.
- Sits between the SoC bus masters (CPU, external masters) and the interconnect's single master input. Lets the SoC collapse multiple masters before address decoding.
- Grant is held for a whole bus cycle (cyc high). Optional watchdog terminates hung transfers with err.

Parameters:
- MASTER_COUNT, 2, number of upstream masters (1..8).
- DATA_WIDTH, 32, mosi/miso width; sel width is DATA_WIDTH/8.
- ADDR_WIDTH, 32, address width.
- TAG_WIDTH, 4, per-master tag width.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  reset, asynchronous, active-high.
- m_cyc  in  MASTER_COUNT  upstream cyc, bit i = master i.
- m_stb  in  MASTER_COUNT  upstream stb.
- m_we  in  MASTER_COUNT  upstream write enable.
- m_tag  in  MASTER_COUNT*TAG_WIDTH  upstream tags.
- m_sel  in  MASTER_COUNT*DATA_WIDTH/8  byte selects.
- m_adr  in  MASTER_COUNT*ADDR_WIDTH  addresses.
- m_mosi  in  MASTER_COUNT*DATA_WIDTH  write data.
- m_miso  out  MASTER_COUNT*DATA_WIDTH  read data, replicated s_miso.
- m_ack  out  MASTER_COUNT  ack; only the granted bit can be 1.
- m_err  out  MASTER_COUNT  err; only the granted bit can be 1.
- s_cyc, s_stb, s_we  out  1 each  downstream control.
- s_tag  out  TAG_WIDTH  downstream tag.
- s_sel  out  DATA_WIDTH/8  downstream byte selects.
- s_adr  out  ADDR_WIDTH  downstream address.
- s_mosi  out  DATA_WIDTH  downstream write data.
- s_miso  in  DATA_WIDTH  downstream read data.
- s_ack  in  1  downstream ack.
- s_err  in  1  downstream err.
- grant  out  MASTER_COUNT  one-hot current owner, for debug.

Behaviour:
- Reset (async assert):
  - State IDLE, grant=0, last_owner = MASTER_COUNT-1.
  - All s_* outputs 0; m_ack=0, m_err=0.
  - Reset release is synchronous to sys_clk.
- State IDLE:
  - s_cyc=0, s_stb=0, m_ack=0, m_err=0.
  - If any m_cyc is high, register grant = first requester searching last_owner+1, last_owner+2, … with wrap modulo MASTER_COUNT. Move to BUSY.
  - Arbitration latency: 1 cycle from m_cyc to s_cyc.
- State BUSY (owner k):
  - s_cyc = m_cyc[k]; s_stb, s_we, s_tag, s_sel, s_adr, s_mosi are muxed combinationally from master k.
  - m_ack[k] = s_ack, m_err[k] = s_err; all other bits 0.
  - Exit: when m_cyc[k] falls, s_cyc drops in the same cycle (combinational). Next state IDLE, last_owner = k, grant = 0.
  - Always one idle bubble between owners, so no back-to-back ownership change.
- No preemption: other requests wait while master k holds cyc, regardless of duration.
- Simultaneous requests: resolved only by the round-robin pointer. With continuous requests from all masters, each is served once per MASTER_COUNT grants.
- A master whose cyc drops before it is granted is simply skipped.
- Acks arriving while in IDLE are dropped (never routed).
- Reset during BUSY: s_cyc drops immediately; the in-flight transfer is abandoned.
- m_miso is broadcast to all masters; masters qualify it with their own ack.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - In BUSY, a counter increments each cycle that s_stb=1 or an ack is outstanding, and clears on s_ack or s_err.
  - When the count reaches TIMEOUT_CYCLES-1 with no response, pulse m_err[k]=1 for exactly one cycle and force s_cyc=0 from that cycle on until master k drops cyc.
  - Then return to IDLE normally. A sticky output timeout_flag (1 bit) sets and clears only on reset.
- Not defined: no counter and no timeout_flag port; a hung slave holds the grant forever.

Decomposition:
- Shared package: WB state encoding (ARB_IDLE, ARB_BUSY) and a round-robin next-owner function.
- Natural sub-module: rr_pick (combinational request vector + last_owner -> one-hot pick). The arbiter registers its output.

Test Plan:
- Single master: m_cyc=01, read at adr 0x4000. s_cyc rises 1 cycle later; slave returns ack with miso 0xDEADBEEF -> m_ack=01, m_miso[31:0]=0xDEADBEEF.
- Contention after reset: m_cyc=11 simultaneously -> master 0 granted first. After it drops cyc, 1 idle cycle, then grant=10.
- Fairness, MASTER_COUNT=3: all masters continuously request 1-beat cycles -> grant order 0,1,2,0,1,2. No master is granted twice in a row.
- Hold: master 0 issues 4 pipelined stb beats under one cyc while master 1 requests -> all 4 acks reach master 0, and m_ack[1] stays 0 until master 0 releases.
- Async reset mid-BUSY: assert sys_rst between edges -> s_cyc=0 and grant=0 before the next edge. After release, master 0 is granted first.
- WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16: slave never acks -> m_err[k] pulses exactly once, 16 cycles after stb; s_cyc=0 after that; timeout_flag=1.
